// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver with 2-flop pin synchronizer and a one-byte valid/ready output register.
// Byte lands C/2+9C cycles after the start edge; no stall path: an unconsumed byte turns the next good byte into an overrun pulse.
module uart_rx_byte #(
  parameter int clk_mhz   = 100,
  parameter int baud_rate = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       frame_error,
  output logic       overrun
);

  localparam int C    = (clk_mhz * 1_000_000) / baud_rate;
  localparam int HALF = C / 2;
  localparam int CW   = (C > 4) ? $clog2(C) : 2;

  localparam logic [CW-1:0] LAST_CNT = CW'(C - 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(HALF - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  generate
    if (C < 4) begin : g_bad_rate
      $error("uart_rx_byte: clk_mhz*1e6/baud_rate must be at least 4");
    end
  endgenerate

  logic          sync_q;
  logic          rx_s_q;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q && !out_ready;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        // Mid-start-bit check: a line that is already high again was a glitch.
        if (cnt_q == HALF_CNT) begin
          cnt_d = '0;
          if (rx_s_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            idx_d   = 3'd0;
          end
        end
      end
      S_DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          if (rx_s_q) begin
            state_d = S_IDLE;
            // An accept on this same edge frees the register for the new byte.
            if (!valid_q || out_ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= 1'b1;
      rx_s_q  <= 1'b1;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= rx;
      rx_s_q  <= sync_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out_data    = data_q;
  assign out_valid   = valid_q;
  assign busy        = (state_q != S_IDLE);
  assign frame_error = ferr_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte at C=10: directed frames plus random frames, each compared
// against a frame-level model of the output register (deliver / overrun / framing error).
module tb_uart_rx_byte;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       busy;
  logic       frame_error;
  logic       overrun;

  uart_rx_byte #(.clk_mhz(1), .baud_rate(100000)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .frame_error (frame_error),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int stray   = 0;

  // Model of the output register as the consumer should see it between frames.
  logic       exp_valid;
  logic [7:0] exp_data;

  // Observations from the most recent frame; index j counts negedges from the start-bit drive.
  int         fe_cnt, ov_cnt, fe_at, ov_at, rise_cyc;
  logic       v97, v98, b2, b3, b98, busy_hold, b_last;
  logic [7:0] d98;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic line_bit(input logic [7:0] b, input logic s, input int j);
    if (j < 10) return 1'b0;
    if (j < 90) return b[(j - 10) / 10];
    return s;
  endfunction

  task automatic idle(input int n);
    rx = 1'b1;
    out_ready = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (frame_error || overrun) stray++;
    end
  endtask

  // mode 0: never ready, 1: ready throughout, 2: ready only for the completion edge.
  task automatic send_frame(input logic [7:0] b, input logic s, input int stop_len,
                            input int mode, input int rst_at);
    int   total;
    logic prev_v;
    total = 90 + stop_len;
    fe_cnt = 0; ov_cnt = 0; fe_at = -1; ov_at = -1; rise_cyc = -1;
    busy_hold = 1'b1; prev_v = out_valid;
    v97 = 1'b0; v98 = 1'b0; d98 = 8'h00; b2 = 1'b0; b3 = 1'b0; b98 = 1'b0; b_last = 1'b0;
    for (int j = 0; j <= total; j++) begin
      if (frame_error) begin fe_cnt++; if (fe_at < 0) fe_at = j; end
      if (overrun) begin ov_cnt++; if (ov_at < 0) ov_at = j; end
      if (j > 0 && out_valid && !prev_v && rise_cyc < 0) rise_cyc = cyc;
      prev_v = out_valid;
      if (j == 2) b2 = busy;
      if (j == 3) b3 = busy;
      if (j >= 3 && j <= 97 && !busy) busy_hold = 1'b0;
      if (j == 97) v97 = out_valid;
      if (j == 98) begin v98 = out_valid; d98 = out_data; b98 = busy; end
      if (j == total) begin
        b_last = busy;
      end else if (j == rst_at) begin
        rst = 1'b1; rx = 1'b1; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        return;
      end else begin
        rx = line_bit(b, s, j);
        out_ready = (mode == 1) || (mode == 2 && j == 97);
        @(negedge clk);
      end
    end
  endtask

  task automatic run_frame(input string tag, input logic [7:0] b, input logic s,
                           input int stop_len, input int mode);
    logic pre_v, exp_v97, deliver, exp_ov, exp_v98;
    pre_v   = exp_valid;
    exp_v97 = (mode == 1) ? 1'b0 : pre_v;
    deliver = s && (!pre_v || mode != 0);
    exp_ov  = s && pre_v && (mode == 0);
    exp_v98 = deliver || (mode == 0 && pre_v);
    if (deliver) exp_data = b;
    send_frame(b, s, stop_len, mode, -1);
    check({tag, ".busy_idle"},  b2, 0);
    check({tag, ".busy_start"}, b3, 1);
    check({tag, ".busy_hold"},  busy_hold, 1);
    check({tag, ".busy_stop"},  b98, !s);
    check({tag, ".busy_last"},  b_last, !s);
    check({tag, ".vld_early"},  v97, exp_v97);
    check({tag, ".vld"},        v98, exp_v98);
    if (exp_v98) check({tag, ".data"}, d98, exp_data);
    check({tag, ".fe_cnt"},     fe_cnt, s ? 0 : 1);
    check({tag, ".ov_cnt"},     ov_cnt, exp_ov ? 1 : 0);
    if (!s)     check({tag, ".fe_at"}, fe_at, 98);
    if (exp_ov) check({tag, ".ov_at"}, ov_at, 98);
    exp_valid = (mode == 1) ? 1'b0 : exp_v98;
  endtask

  task automatic consume(input string tag);
    check({tag, ".vld_before"}, out_valid, exp_valid);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".vld_after"}, out_valid, 0);
    exp_valid = 1'b0;
  endtask

  task automatic glitch();
    int nb, first, pulses, vbad;
    nb = 0; first = -1; pulses = 0; vbad = 0;
    for (int j = 0; j <= 30; j++) begin
      if (busy) begin nb++; if (first < 0) first = j; end
      if (frame_error || overrun) pulses++;
      if (out_valid !== exp_valid) vbad++;
      rx = (j < 3) ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    check("glitch.busy_cycles", nb, 5);
    check("glitch.busy_first", first, 3);
    check("glitch.pulses", pulses, 0);
    check("glitch.vld", vbad, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r0;
    rst = 1'b1; rx = 1'b1; out_ready = 1'b0;
    exp_valid = 1'b0; exp_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst.vld",  out_valid, 0);
    check("rst.data", out_data, 8'h00);
    check("rst.busy", busy, 0);
    check("rst.fe",   frame_error, 0);
    check("rst.ov",   overrun, 0);
    rst = 1'b0;
    idle(50);
    check("idle.vld",  out_valid, 0);
    check("idle.data", out_data, 8'h00);
    check("idle.busy", busy, 0);

    run_frame("b55", 8'h55, 1'b1, 10, 0);
    idle(100);
    check("b55.hold_vld",  out_valid, 1);
    check("b55.hold_data", out_data, 8'h55);
    consume("b55");

    glitch();

    run_frame("fe_a3", 8'hA3, 1'b0, 50, 0);
    idle(5);
    run_frame("b3c", 8'h3C, 1'b1, 10, 0);
    idle(5);
    consume("b3c");

    run_frame("b11", 8'h11, 1'b1, 10, 0);
    idle(5);
    run_frame("ovr22", 8'h22, 1'b1, 10, 0);
    idle(5);
    run_frame("acc22", 8'h22, 1'b1, 10, 2);
    idle(5);
    consume("acc22");

    run_frame("b2b00", 8'h00, 1'b1, 10, 1);
    r0 = rise_cyc;
    run_frame("b2bff", 8'hFF, 1'b1, 10, 1);
    check("b2b.gap", rise_cyc - r0, 100);
    idle(5);

    send_frame(8'hC6, 1'b1, 10, 1, 52);
    exp_valid = 1'b0; exp_data = 8'h00;
    check("midrst.busy", busy, 0);
    check("midrst.vld",  out_valid, 0);
    check("midrst.data", out_data, 8'h00);
    check("midrst.fe",   fe_cnt, 0);
    idle(20);
    check("midrst.quiet_vld", out_valid, 0);
    run_frame("b5a", 8'h5A, 1'b1, 10, 1);
    idle(5);

    for (int i = 0; i < 20; i++) begin
      logic [7:0] b;
      logic       s;
      int         mode;
      b    = 8'($urandom);
      s    = ($urandom_range(0, 7) != 0);
      mode = $urandom_range(0, 2);
      run_frame($sformatf("rnd%0d", i), b, s, 10, mode);
      idle($urandom_range(2, 15));
      if (exp_valid && $urandom_range(0, 1) == 1) consume($sformatf("rnd%0d", i));
    end

    check("stray_pulses", stray, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
